gyro_frame_rx: RTL
==================

Name: gyro_frame_rx

Overview:
- Downstream capture stage for the gyro_top serial outputs DTX, DSYNC and SYNCK.
- Oversamples the serial bit clock in the system clock domain and deserialises DSYNC-framed data into words.
- Buffers the words in a small FIFO and presents them on an AXI-Stream-style master port to the tester DMA/S2MM path.
- Provides frame, overflow and sync-error status for the CPU register block.

Parameters:
- WORD_W, 16, bits per word; MSB first on the line.
- WORDS_PER_FRAME, 4, words per DSYNC frame.
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 4.
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ser_clk  in  1  serial bit clock (gyro SYNCK); asynchronous to clk.
- ser_sync  in  1  frame sync (gyro DSYNC); high during the first bit of a frame.
- ser_data  in  1  serial data (gyro DTX).
- enable  in  1  capture enable; when low, the FSM is held in IDLE.
- m_tdata  out  WORD_W  output word.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  sink ready.
- m_tlast  out  1  set on the last word of a frame.
- frame_cnt  out  CNT_W  count of completed frames.
- ovf_cnt  out  CNT_W  count of words dropped on a full FIFO.
- err_cnt  out  CNT_W  count of aborted frames (sync error).
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, synchronisers cleared.
- Input synchronisation:
  - ser_clk, ser_sync and ser_data each pass through a 2-FF synchroniser, plus one history flop on ser_clk.
  - Bit strobe = synchronised ser_clk rising edge (s1 & ~s2), one clk wide.
  - On the strobe, sample the synchronised sync and data.
  - Requirement: ser_clk frequency <= clk/4.
- FSM states:
  - IDLE: on strobe with sync=1 and enable=1, load data into shift[0], set bit_cnt=1 and word_cnt=0, go to SHIFT. Sync=0 strobes are ignored.
  - SHIFT: on each strobe, shift in data MSB first and increment bit_cnt.
    - Sync=1 on any strobe other than the first bit of a word boundary: abort the frame, increment err_cnt (saturating), discard the partial word, and restart as a new frame with this bit as bit 0.
    - bit_cnt reaching WORD_W: go to PUSH.
  - PUSH (one cycle): write {word, last} to the FIFO, where last = (word_cnt == WORDS_PER_FRAME-1).
    - If last: increment frame_cnt (saturating) and go to IDLE.
    - Otherwise: increment word_cnt, clear bit_cnt, go to SHIFT.
    - A strobe cannot coincide with PUSH because of the clk/4 rule. Any strobe that does arrive in PUSH is held and processed in the next cycle.
- Word boundaries:
  - Sync=1 exactly at bit 0 of word N (N>0) is a frame restart. It increments err_cnt only if the previous frame was incomplete.
  - After the last word, a sync=1 strobe in IDLE starts a new frame with no gap required.
- enable low: drives the FSM to IDLE immediately and discards the partial word. Words already in the FIFO still drain.
- FIFO behaviour:
  - Synchronous, FIFO_DEPTH entries of WORD_W+1 bits.
  - A write when full drops the word and increments ovf_cnt (saturating).
  - A dropped last word still counts the frame in frame_cnt.
  - Simultaneous read and write when full: the read frees an entry, so the write succeeds.
- Output handshake:
  - m_tvalid = FIFO not empty; m_tdata and m_tlast come from the FIFO head.
  - A transfer occurs when m_tvalid & m_tready.
  - m_tdata and m_tlast are stable while m_tvalid is high and m_tready is low.
- Latency: from the last-bit strobe to m_tvalid is 2 clk with the FIFO empty (PUSH, then write). Synchroniser delay from a ser_clk edge to the strobe is 2–3 clk.
- Counters: saturate at all-ones and do not wrap. They are cleared only by rst.
- busy = (state != IDLE).

Test Plan:
- Nominal frame: ser_clk=clk/8, WORD_W=16, words 0xA5A5, 0x1234, 0xFFFF, 0x0001 with sync on bit 0, m_tready=1 -> 4 beats in order, m_tlast only on 0x0001, frame_cnt=1, err_cnt=0.
- Back-to-back frames: 3 frames with no idle gap -> 12 beats, m_tlast on beats 4, 8 and 12, frame_cnt=3.
- Backpressure/overflow: FIFO_DEPTH=16, m_tready=0, 5 frames (20 words) -> first 16 words held in order, ovf_cnt=4, frame_cnt=5; raise m_tready -> 16 beats drain with m_tdata stable during stalls.
- Sync error: sync pulse at bit 7 of word 1 -> err_cnt=1, partial words not emitted, new frame captured from that bit and emitted correctly.
- Enable/reset mid-frame: drop enable after word 2 -> FSM to IDLE, only 2 beats emitted with no m_tlast. Assert rst asynchronously while m_tvalid=1 -> m_tvalid=0 and all counters 0 immediately.

Source files
------------

// File: rtl/gyro_frame_rx_if.sv
// AXI-Stream-style word port between the gyro capture stage and the tester DMA/S2MM sink.
// The master drives tdata/tvalid/tlast and the sink returns tready.
interface gyro_frame_rx_if #(
  parameter int WORD_W = 16
);
  logic [WORD_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gyro_frame_rx.sv
// Gyro serial capture: oversamples SYNCK/DSYNC/DTX, deserialises DSYNC-framed words into a FIFO.
// Last-bit strobe to m.tvalid is 2 clk on an empty FIFO; a full FIFO drops words and counts them in ovf_cnt.
module gyro_frame_rx #(
  parameter int WORD_W          = 16,
  parameter int WORDS_PER_FRAME = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_clk,
  input  logic             ser_sync,
  input  logic             ser_data,
  input  logic             enable,
  gyro_frame_rx_if.master  m,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);
  localparam int BC_W  = $clog2(WORD_W + 1);
  localparam int WC_W  = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [BC_W-1:0]  BIT_LAST  = BC_W'(WORD_W);
  localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(WORDS_PER_FRAME - 1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // ser_clk carries an extra history stage for edge detection
  logic [2:0] sclk_q, sclk_d;
  logic [1:0] ssync_q, ssync_d, sdata_q, sdata_d;
  logic       strobe, s_sync, s_data;

  logic       pend_q, pend_d, pend_sync_q, pend_sync_d, pend_data_q, pend_data_d;
  logic       stb, stb_sync, stb_data;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic              push, word_last, frame_inc, err_inc, ovf_inc;

  logic [WORD_W:0]   mem_q [FIFO_DEPTH];
  logic [WORD_W:0]   head;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
  logic              empty, full, rd_en, wr_en;

  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d, ovf_cnt_q, ovf_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    sclk_d  = {sclk_q[1:0], ser_clk};
    ssync_d = {ssync_q[0], ser_sync};
    sdata_d = {sdata_q[0], ser_data};
    strobe  = sclk_q[1] & ~sclk_q[2];
    s_sync  = ssync_q[1];
    s_data  = sdata_q[1];
  end

  // A strobe landing in PUSH is replayed on the following cycle
  always_comb begin
    stb      = strobe;
    stb_sync = s_sync;
    stb_data = s_data;
    if (pend_q) begin
      stb      = 1'b1;
      stb_sync = pend_sync_q;
      stb_data = pend_data_q;
    end
    pend_d      = 1'b0;
    pend_sync_d = pend_sync_q;
    pend_data_d = pend_data_q;
    if ((state_q == PUSH) && strobe) begin
      pend_d      = 1'b1;
      pend_sync_d = s_sync;
      pend_data_d = s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    word_cnt_d  = word_cnt_q;
    bit_cnt_inc = bit_cnt_q + BC_W'(1);
    case (state_q)
      IDLE: begin
        if (enable && stb && stb_sync) begin
          state_d    = SHIFT;
          shift_d    = {{(WORD_W-1){1'b0}}, stb_data};
          bit_cnt_d  = BC_W'(1);
          word_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (stb) begin
          if (stb_sync) begin
            // Any sync inside SHIFT means the current frame is incomplete: restart here
            shift_d    = {{(WORD_W-1){1'b0}}, stb_data};
            bit_cnt_d  = BC_W'(1);
            word_cnt_d = '0;
          end else begin
            shift_d   = {shift_q[WORD_W-2:0], stb_data};
            bit_cnt_d = bit_cnt_inc;
            if (bit_cnt_inc == BIT_LAST) begin
              state_d = PUSH;
            end
          end
        end
      end
      PUSH: begin
        if (word_last) begin
          state_d = IDLE;
        end else begin
          word_cnt_d = word_cnt_q + WC_W'(1);
          bit_cnt_d  = '0;
          state_d    = enable ? SHIFT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    push      = (state_q == PUSH);
    word_last = (word_cnt_q == WORD_LAST);
    frame_inc = push & word_last;
    err_inc   = (state_q == SHIFT) & enable & stb & stb_sync;
  end

  always_comb begin
    fill     = wr_ptr_q - rd_ptr_q;
    empty    = (fill == '0);
    full     = (fill == FIFO_FULL);
    rd_en    = ~empty & m.tready;
    wr_en    = push & (~full | rd_en);
    ovf_inc  = push & full & ~rd_en;
    wr_ptr_d = wr_ptr_q + (wr_en ? (PTR_W+1)'(1) : '0);
    rd_ptr_d = rd_ptr_q + (rd_en ? (PTR_W+1)'(1) : '0);
    head     = mem_q[rd_ptr_q[PTR_W-1:0]];
    m.tvalid = ~empty;
    m.tdata  = empty ? '0 : head[WORD_W:1];
    m.tlast  = ~empty & head[0];
  end

  always_comb begin
    frame_cnt_d = sat_inc(frame_cnt_q, frame_inc);
    ovf_cnt_d   = sat_inc(ovf_cnt_q, ovf_inc);
    err_cnt_d   = sat_inc(err_cnt_q, err_inc);
    frame_cnt   = frame_cnt_q;
    ovf_cnt     = ovf_cnt_q;
    err_cnt     = err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {shift_q, word_last};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q      <= '0;
      ssync_q     <= '0;
      sdata_q     <= '0;
      pend_q      <= 1'b0;
      pend_sync_q <= 1'b0;
      pend_data_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_cnt_q <= '0;
      ovf_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      sclk_q      <= sclk_d;
      ssync_q     <= ssync_d;
      sdata_q     <= sdata_d;
      pend_q      <= pend_d;
      pend_sync_q <= pend_sync_d;
      pend_data_q <= pend_data_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end
endmodule
